// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative RV32M multiply/divide unit with valid/ready handshake
module alu_muldiv_seq #(
    parameter int XLEN = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            negative_flag,
    output logic            overflow_flag,
    output logic            div_by_zero_flag,
    output logic            busy
);
    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_DIV = 3'b100, OP_REM = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]        op_r;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN:0]     rem;
    logic [CNT_W-1:0]  cnt;
    logic              sign_diff, sign_a;

    // operand preparation at accept
    logic              accept, signed_a, signed_b, neg_a, neg_b, is_div, dbz, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;
    assign accept   = in_valid && in_ready;
    assign is_div   = op[2];
    assign signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign neg_a    = signed_a && operand_a[XLEN-1];
    assign neg_b    = signed_b && operand_b[XLEN-1];
    assign mag_a    = neg_a ? -operand_a : operand_a;
    assign mag_b    = neg_b ? -operand_b : operand_b;
    assign dbz      = is_div && (operand_b == '0);
    assign ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                      (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    // op[1] distinguishes REM/REMU from DIV/DIVU among divide ops
    assign fast_res = dbz ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);

    // one iteration of shift-add multiply and restoring divide
    logic [XLEN:0]     mul_sum, shifted, diff;
    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, b_mag};
    assign shifted = {rem[XLEN-1:0], quot[XLEN-1]};
    assign diff    = shifted - {1'b0, b_mag};

    // sign correction and result select during FIX
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;
    always_comb begin
        prod_fix = sign_diff ? -prod : prod;
        quot_fix = sign_diff ? -quot : quot;
        rem_fix  = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        fix_res  = '0;
        case (op_r)
            OP_MUL:                fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:        fix_res = quot_fix;
            default:               fix_res = rem_fix;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (dbz || ovf) ? DONE : CALC;
            CALC: if (cnt == CNT_W'(XLEN-1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath, iteration counter and registered result/flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r <= '0; b_mag <= '0; prod <= '0; quot <= '0; rem <= '0; cnt <= '0;
            sign_diff <= 1'b0; sign_a <= 1'b0;
            result <= '0; zero_flag <= 1'b0; negative_flag <= 1'b0;
            overflow_flag <= 1'b0; div_by_zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_r      <= op;
                    b_mag     <= mag_b;
                    prod      <= {{XLEN{1'b0}}, mag_a};
                    quot      <= mag_a;
                    rem       <= '0;
                    cnt       <= '0;
                    sign_diff <= neg_a ^ neg_b;
                    sign_a    <= neg_a;
                    if (dbz || ovf) begin
                        result           <= fast_res;
                        zero_flag        <= (fast_res == '0);
                        negative_flag    <= fast_res[XLEN-1];
                        overflow_flag    <= ovf && !dbz;
                        div_by_zero_flag <= dbz;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_r[2]) begin
                        if (diff[XLEN]) begin
                            rem  <= shifted;
                            quot <= {quot[XLEN-2:0], 1'b0};
                        end else begin
                            rem  <= diff;
                            quot <= {quot[XLEN-2:0], 1'b1};
                        end
                    end else begin
                        prod <= prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
                    end
                end
                FIX: begin
                    result           <= fix_res;
                    zero_flag        <= (fix_res == '0);
                    negative_flag    <= fix_res[XLEN-1];
                    overflow_flag    <= 1'b0;
                    div_by_zero_flag <= 1'b0;
                end
                DONE: if (out_ready) begin
                    result <= '0; zero_flag <= 1'b0; negative_flag <= 1'b0;
                    overflow_flag <= 1'b0; div_by_zero_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative multi-cycle execution unit for the RV32M multiply/divide ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Width is parametrised by XLEN.
- Sits beside the single-cycle ALU in the execute stage and is selected when the decoded instruction is M-extension.
- Uses a valid/ready handshake on input and output so the pipeline can stall on it.
- Reports zero/negative/overflow flags, plus a divide-by-zero flag.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  XLEN  rs1 value.
- operand_b  input  XLEN  rs2 value.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  op result.
- zero_flag  output  1  result == 0.
- negative_flag  output  1  result[XLEN-1].
- overflow_flag  output  1  signed DIV/REM overflow case.
- div_by_zero_flag  output  1  DIV/DIVU/REM/REMU with operand_b == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0 except in_ready=1.
  - Internal accumulators and counter cleared.
  - Reset mid-operation aborts the op with no result produced.
- FSM states: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE). Accept occurs at the edge where in_valid & in_ready. op and operands are latched at that edge and not resampled afterwards.
- IDLE -> CALC on accept. Operand preparation at accept:
  - Signed ops (MULH, DIV, REM): both operands converted to magnitude, sign recorded.
  - MULHSU: only operand_a is treated as signed.
  - Unsigned ops: operands used as-is.
- Fast path at accept, IDLE -> DONE directly with result valid at the next edge (latency 1):
  - Divide by zero (any div/rem op, operand_b==0): quotient = all ones; remainder = operand_a unchanged; div_by_zero_flag=1.
  - Signed overflow (DIV/REM, operand_a = 1<<(XLEN-1), operand_b = all ones): DIV result = operand_a; REM result = 0; overflow_flag=1.
- CALC runs exactly XLEN iterations, one per cycle, counter 0..XLEN-1, then goes to FIX.
  - Multiply: shift-add over a 2*XLEN product register, one multiplier bit per iteration.
  - Divide: restoring division producing one quotient bit per iteration, with XLEN+1-bit partial remainder.
- FIX (one cycle): sign correction and result select, then DONE.
  - Product negated if the operand signs differ.
  - Quotient negated if dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Result select: MUL = product low half; MULH/MULHSU/MULHU = product high half; DIV/DIVU = quotient; REM/REMU = remainder.
- Normal latency: out_valid rises XLEN+2 cycles after the accept edge (34 for XLEN=32).
- DONE: out_valid=1. result and all flags are registered and held stable until out_ready.
  - DONE & out_ready -> IDLE at that edge; out_valid drops.
  - No new accept in the same cycle; earliest next accept is one cycle later.
- Flags:
  - zero_flag and negative_flag are computed from the final result and registered with it.
  - overflow_flag and div_by_zero_flag are 0 for multiply ops and for normal divides.
  - All flags are meaningful only while out_valid=1 and are cleared on return to IDLE.
- in_valid held high while the unit is busy is ignored; no queueing.
- op codes outside the decoded set cannot occur (the field is fully decoded).

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, negative_flag=1, out_valid exactly 34 cycles after accept.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF with div_by_zero_flag=1, out_valid 1 cycle after accept. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 with overflow_flag=1. REM same operands -> 0 with zero_flag=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next edge, in_ready=1.
- Assert reset 10 cycles into a CALC -> immediately out_valid=0, busy=0, in_ready=1. After release, a fresh MUL 3*4 -> 12 with normal latency.
